// File: rtl/button_poll_master.sv
// Polling bus master: configures a button peripheral, periodically reads its edge mask,
// hands nonzero masks downstream over valid/ready, then write-clears the reported bits.
module button_poll_master #(
    parameter int unsigned           NUM_BUTTONS = 8,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           POLL_DIV    = 50000,
    parameter int unsigned           TIMEOUT     = 255,
    parameter logic [DATA_WIDTH-1:0] CFG_WORD    = DATA_WIDTH'(32'h0000_0001)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rd,
    output logic                   we,
    output logic                   register_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   done,
    output logic                   evt_valid,
    output logic [NUM_BUTTONS-1:0] evt_data,
    input  logic                   evt_ready,
    output logic                   cfg_ok,
    output logic                   err
);

    localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StCfgReq,
        StWaitTick,
        StRdReq,
        StPush,
        StClrReq
    } state_e;

    state_e                 state_q, state_d;
    logic [PollW-1:0]       poll_q, poll_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [NUM_BUTTONS-1:0] evt_data_q, evt_data_d;
    logic                   cfg_ok_q, cfg_ok_d;
    logic                   err_q, err_d;
    logic                   tmo_hit;
    logic                   poll_last;
    logic                   unused_rd_data;

    // Only the low NUM_BUTTONS bits of the read payload carry button edges.
    assign unused_rd_data = ^rd_data;

    assign tmo_hit   = (tmo_q == TmoW'(TIMEOUT - 1));
    assign poll_last = (poll_q == PollW'(POLL_DIV - 1));

    always_comb begin
        state_d       = state_q;
        poll_d        = '0;
        tmo_d         = '0;
        evt_data_d    = evt_data_q;
        cfg_ok_d      = cfg_ok_q;
        err_d         = err_q;
        rd            = 1'b0;
        we            = 1'b0;
        register_addr = 1'b0;
        wr_data       = '0;
        evt_valid     = 1'b0;

        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = cfg_ok_q ? StWaitTick : StCfgReq;
                end
            end
            StCfgReq: begin
                we      = 1'b1;
                wr_data = CFG_WORD;
                if (done) begin
                    cfg_ok_d = 1'b1;
                    state_d  = StWaitTick;
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    cfg_ok_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitTick: begin
                // Disable wins over a due poll so no new transfer starts once en drops.
                if (!en) begin
                    state_d = StIdle;
                end else if (poll_last) begin
                    state_d = StRdReq;
                end else begin
                    poll_d = poll_q + PollW'(1);
                end
            end
            StRdReq: begin
                rd            = 1'b1;
                register_addr = 1'b1;
                if (done) begin
                    evt_data_d = rd_data[NUM_BUTTONS-1:0];
                    state_d    = (|rd_data[NUM_BUTTONS-1:0]) ? StPush : StWaitTick;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StWaitTick;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StPush: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    state_d = StClrReq;
                end
            end
            StClrReq: begin
                we            = 1'b1;
                register_addr = 1'b1;
                wr_data       = DATA_WIDTH'(evt_data_q);
                if (done) begin
                    state_d = StWaitTick;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StWaitTick;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            poll_q     <= '0;
            tmo_q      <= '0;
            evt_data_q <= '0;
            cfg_ok_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_q     <= poll_d;
            tmo_q      <= tmo_d;
            evt_data_q <= evt_data_d;
            cfg_ok_q   <= cfg_ok_d;
            err_q      <= err_d;
        end
    end

    assign evt_data = evt_data_q;
    assign cfg_ok   = cfg_ok_q;
    assign err      = err_q;

endmodule

// File: tb/tb_button_poll_master.sv
// Self-checking bench for button_poll_master: a peripheral responder with random latencies and
// masks, checked against bus-timing expectations derived from the polling rules.
module tb_button_poll_master;

    localparam int NB = 8;
    localparam int DW = 32;
    localparam int PD = 6;
    localparam int TO = 4;
    localparam logic [31:0] CFGW = 32'h0000_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rd;
    logic          we;
    logic          register_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          evt_valid;
    logic [NB-1:0] evt_data;
    logic          evt_ready;
    logic          cfg_ok;
    logic          err;

    int errors = 0;
    int checks = 0;

    // Model state carried across scenarios.
    logic          err_exp = 1'b0;
    logic [NB-1:0] cap_exp = '0;

    button_poll_master #(
        .NUM_BUTTONS(NB),
        .DATA_WIDTH (DW),
        .POLL_DIV   (PD),
        .TIMEOUT    (TO),
        .CFG_WORD   (CFGW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .rd           (rd),
        .we           (we),
        .register_addr(register_addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .done         (done),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_ready    (evt_ready),
        .cfg_ok       (cfg_ok),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Counts idle negedges (no rd/we) until a request appears; n = limit+1 if none appears.
    task automatic idle_until_req(input int limit, input bit noise, output int n);
        n = 0;
        while (!(rd || we) && n <= limit) begin
            n++;
            done    = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            rd_data = $urandom;
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    // Peripheral responder: answers done in cycle lat of the request (lat=0 never answers).
    task automatic serve(input int lat, input logic [31:0] rdata, output int hi,
                         output logic [3:0] first, output logic [31:0] first_wd,
                         output bit steady);
        first    = {rd, we, register_addr, evt_valid};
        first_wd = wr_data;
        steady   = 1'b1;
        hi       = 0;
        while ((rd || we) && hi <= TO + 2) begin
            hi++;
            if ({rd, we, register_addr, evt_valid} !== first || wr_data !== first_wd) begin
                steady = 1'b0;
            end
            done    = (hi == lat);
            rd_data = (hi == lat) ? rdata : $urandom;
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    // Stalls evt_ready for delay cycles, recording whether the offered event stayed put.
    task automatic push(input int delay, output bit stable);
        logic [NB-1:0] held;
        held   = evt_data;
        stable = 1'b1;
        for (int i = 0; i < delay; i++) begin
            evt_ready = 1'b0;
            @(negedge clk);
            if (!evt_valid || evt_data !== held || rd || we) stable = 1'b0;
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b0; done = 1'b0; evt_ready = 1'b0; rd_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd, we, register_addr, evt_valid, cfg_ok, err} !== 6'b0 || wr_data !== '0
            || evt_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b we=%b addr=%b ev=%b cfg=%b err=%b wd=%h ed=%h, want all 0",
                     rd, we, register_addr, evt_valid, cfg_ok, err, wr_data, evt_data);
        end
        rst = 1'b0;
        idle_until_req(5, 1'b1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL idle_when_disabled: request after %0d cycles, want none within 6", n);
        end
    endtask

    task automatic test_startup();
        int n, hi;
        logic [3:0] f;
        logic [31:0] fw;
        bit st;
        en = 1'b1;
        @(negedge clk);
        idle_until_req(3, 1'b0, n);
        checks++;
        if (n !== 0 || cfg_ok !== 1'b0) begin
            errors++;
            $display("FAIL cfg_start: delay=%0d cfg_ok=%b, want 0 and 0", n, cfg_ok);
        end
        serve(3, $urandom, hi, f, fw, st);
        checks++;
        if (f !== 4'b0100 || fw !== CFGW || !st) begin
            errors++;
            $display("FAIL cfg_shape: got {rd,we,addr,ev}=%b wd=%h steady=%0d, want 0100 %h 1",
                     f, fw, st, CFGW);
        end
        checks++;
        if (hi !== 3) begin
            errors++;
            $display("FAIL cfg_len: got %0d cycles, want 3", hi);
        end
        checks++;
        if (cfg_ok !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ok_set: got %b, want 1", cfg_ok);
        end
        idle_until_req(PD + 3, 1'b1, n);
        checks++;
        if (n !== PD || rd !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL first_poll: gap=%0d rd=%b we=%b, want %0d 1 0", n, rd, we, PD);
        end
    endtask

    task automatic test_event();
        int n, hi, lat;
        logic [3:0] f;
        logic [31:0] fw;
        bit st;
        lat = $urandom_range(1, TO);
        serve(lat, 32'h0000_0005, hi, f, fw, st);
        cap_exp = 8'h05;
        checks++;
        if (f !== 4'b1010 || fw !== 32'h0 || !st || hi !== lat) begin
            errors++;
            $display("FAIL evt_read: got %b wd=%h steady=%0d len=%0d, want 1010 0 1 %0d",
                     f, fw, st, hi, lat);
        end
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 8'h05) begin
            errors++;
            $display("FAIL evt_offer: got valid=%b data=%h, want 1 05", evt_valid, evt_data);
        end
        push(4, st);
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL evt_stable: event changed or request issued while stalled, want stable");
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL evt_handshake: valid=%b after accept, want 0", evt_valid);
        end
        serve(2, $urandom, hi, f, fw, st);
        checks++;
        if (f !== 4'b0110 || fw !== 32'h0000_0005 || !st || hi !== 2) begin
            errors++;
            $display("FAIL clr_write: got %b wd=%h steady=%0d len=%0d, want 0110 00000005 1 2",
                     f, fw, st, hi);
        end
        idle_until_req(PD + 3, 1'b1, n);
        checks++;
        if (n !== PD || rd !== 1'b1) begin
            errors++;
            $display("FAIL poll_after_clr: gap=%0d rd=%b, want %0d 1", n, rd, PD);
        end
    endtask

    task automatic test_no_event();
        int n, hi;
        logic [3:0] f;
        logic [31:0] fw;
        bit st;
        serve(1, 32'hABCD_1200, hi, f, fw, st);
        cap_exp = 8'h00;
        checks++;
        if (evt_valid !== 1'b0 || evt_data !== 8'h00 || hi !== 1) begin
            errors++;
            $display("FAIL noevt_capture: valid=%b data=%h len=%0d, want 0 00 1",
                     evt_valid, evt_data, hi);
        end
        idle_until_req(PD + 3, 1'b1, n);
        checks++;
        if (n !== PD || rd !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL noevt_next: gap=%0d rd=%b we=%b, want %0d 1 0", n, rd, we, PD);
        end
    endtask

    task automatic test_timeout();
        int n, hi;
        logic [3:0] f;
        logic [31:0] fw;
        bit st;
        serve(0, 32'h0, hi, f, fw, st);
        err_exp = 1'b1;
        checks++;
        if (hi !== TO || err !== 1'b1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_timeout: len=%0d err=%b valid=%b, want %0d 1 0",
                     hi, err, evt_valid, TO);
        end
        idle_until_req(PD + 3, 1'b1, n);
        checks++;
        if (n !== PD || rd !== 1'b1) begin
            errors++;
            $display("FAIL resume_after_timeout: gap=%0d rd=%b, want %0d 1", n, rd, PD);
        end
    endtask

    task automatic test_random();
        int n, hi, lat, clat, exp_hi;
        logic [3:0] f;
        logic [31:0] fw;
        logic [7:0] mask;
        logic [31:0] rdat;
        bit st, ev;
        for (int it = 0; it < 12; it++) begin
            lat  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
            mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rdat = ($urandom & 32'hFFFF_FF00) | {24'h0, mask};
            serve(lat, rdat, hi, f, fw, st);
            exp_hi = (lat == 0) ? TO : lat;
            if (lat == 0) err_exp = 1'b1;
            else cap_exp = mask;
            ev = (lat != 0) && (mask != 0);
            checks++;
            if (f !== 4'b1010 || fw !== 32'h0 || !st || hi !== exp_hi) begin
                errors++;
                $display("FAIL rnd_read[%0d]: got %b wd=%h steady=%0d len=%0d, want 1010 0 1 %0d",
                         it, f, fw, st, hi, exp_hi);
            end
            checks++;
            if (evt_valid !== ev || evt_data !== cap_exp || err !== err_exp) begin
                errors++;
                $display("FAIL rnd_after_read[%0d]: valid=%b data=%h err=%b, want %b %h %b",
                         it, evt_valid, evt_data, err, ev, cap_exp, err_exp);
            end
            if (ev) begin
                push($urandom_range(0, 4), st);
                clat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
                serve(clat, $urandom, hi, f, fw, st);
                exp_hi = (clat == 0) ? TO : clat;
                if (clat == 0) err_exp = 1'b1;
                checks++;
                if (f !== 4'b0110 || fw !== {24'h0, mask} || !st || hi !== exp_hi
                    || err !== err_exp) begin
                    errors++;
                    $display("FAIL rnd_clr[%0d]: got %b wd=%h steady=%0d len=%0d err=%b, want 0110 %h 1 %0d %b",
                             it, f, fw, st, hi, err, {24'h0, mask}, exp_hi, err_exp);
                end
            end
            idle_until_req(PD + 3, 1'b1, n);
            checks++;
            if (n !== PD || rd !== 1'b1 || we !== 1'b0) begin
                errors++;
                $display("FAIL rnd_gap[%0d]: gap=%0d rd=%b we=%b, want %0d 1 0", it, n, rd, we, PD);
            end
        end
    endtask

    task automatic test_en_drop();
        int n, hi;
        logic [3:0] f;
        logic [31:0] fw;
        bit st;
        en = 1'b0;
        serve(2, 32'h0000_0081, hi, f, fw, st);
        cap_exp = 8'h81;
        checks++;
        if (hi !== 2 || evt_valid !== 1'b1 || evt_data !== 8'h81) begin
            errors++;
            $display("FAIL endrop_read: len=%0d valid=%b data=%h, want 2 1 81",
                     hi, evt_valid, evt_data);
        end
        push(1, st);
        serve(1, $urandom, hi, f, fw, st);
        checks++;
        if (f !== 4'b0110 || fw !== 32'h0000_0081 || hi !== 1) begin
            errors++;
            $display("FAIL endrop_clr: got %b wd=%h len=%0d, want 0110 00000081 1", f, fw, hi);
        end
        idle_until_req(3 * PD, 1'b1, n);
        checks++;
        if (n !== 3 * PD + 1 || evt_valid !== 1'b0 || evt_data !== 8'h81) begin
            errors++;
            $display("FAIL endrop_idle: request after %0d cycles valid=%b data=%h, want none 0 81",
                     n, evt_valid, evt_data);
        end
        en = 1'b1;
        @(negedge clk);
        idle_until_req(PD + 3, 1'b0, n);
        checks++;
        if (n !== PD || rd !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL reenable: gap=%0d rd=%b we=%b, want %0d 1 0", n, rd, we, PD);
        end
    endtask

    task automatic test_reset_mid_and_cfg_timeout();
        int n, hi;
        logic [3:0] f;
        logic [31:0] fw;
        bit st;
        serve(1, 32'h0000_003C, hi, f, fw, st);
        push(0, st);
        checks++;
        if (we !== 1'b1 || wr_data !== 32'h0000_003C) begin
            errors++;
            $display("FAIL pre_reset_clr: we=%b wd=%h, want 1 0000003c", we, wr_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd, we, register_addr, evt_valid, cfg_ok, err} !== 6'b0 || wr_data !== '0
            || evt_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rd=%b we=%b addr=%b ev=%b cfg=%b err=%b wd=%h ed=%h, want all 0",
                     rd, we, register_addr, evt_valid, cfg_ok, err, wr_data, evt_data);
        end
        rst = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || rd !== 1'b0 || register_addr !== 1'b0 || wr_data !== CFGW) begin
            errors++;
            $display("FAIL recfg: we=%b rd=%b addr=%b wd=%h, want 1 0 0 %h",
                     we, rd, register_addr, wr_data, CFGW);
        end
        serve(0, 32'h0, hi, f, fw, st);
        checks++;
        if (hi !== TO || err !== 1'b1 || cfg_ok !== 1'b0) begin
            errors++;
            $display("FAIL cfg_timeout: len=%0d err=%b cfg_ok=%b, want %0d 1 0", hi, err, cfg_ok, TO);
        end
        idle_until_req(4, 1'b0, n);
        checks++;
        if (n !== 1 || we !== 1'b1 || register_addr !== 1'b0) begin
            errors++;
            $display("FAIL cfg_retry: gap=%0d we=%b addr=%b, want 1 1 0", n, we, register_addr);
        end
        serve(2, 32'h0, hi, f, fw, st);
        checks++;
        if (hi !== 2 || cfg_ok !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_recover: len=%0d cfg_ok=%b err=%b, want 2 1 1", hi, cfg_ok, err);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_event();
        test_no_event();
        test_timeout();
        test_random();
        test_en_drop();
        test_reset_mid_and_cfg_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
